lh_msg_feeder: RTL and testbench

LH_MSG_FEEDER -- requirements
Module: lh_msg_feeder

---
 rtl/lh_pkg.sv | 20 ++
 rtl/lh_byte_fifo.sv | 42 ++++
 rtl/lh_msg_feeder.sv | 132 +++++++++++++
 tb/tb_lh_msg_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lh_pkg.sv
// lh_pkg: shared marker bytes, widths and FSM state type for the message feeder
package lh_pkg;
  localparam logic [7:0] START_MARK = 8'hFF;
  localparam logic [7:0] END_MARK = 8'h00;
  localparam int DIGEST_W = 64;
  localparam int ENTRY_W = 9;
  typedef enum logic [2:0] {
    IDLE,
    SEND_START,
    GAP,
    WAIT_CORE,
    FETCH,
    SEND_END,
    WAIT_DIGEST,
    HOLD
  } state_t;
  function automatic logic is_mark(input logic [7:0] c);
    return c == START_MARK || c == END_MARK;
  endfunction
endpackage

// File: rtl/lh_byte_fifo.sv
// lh_byte_fifo: {last, char} entry FIFO with full/empty flags and first-word-fall-through read.
//   clk/rst  clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata  write request and entry; accepted when not full or when popping in the same cycle
//   pop/rdata   read request and head entry (valid whenever empty==0)
//   full/empty  occupancy flags
module lh_byte_fifo
  import lh_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
endmodule

// File: rtl/lh_msg_feeder.sv
// lh_msg_feeder: buffers host message bytes and feeds them to a hash core framed by start/end marks.
//   host side:   msg_char/msg_valid/msg_last in, msg_ready/msg_drop out
//   core side:   ptxt_char/ptxt_valid out; core_busy, digest_char, digest_ready, err_invalid_ptxt_char in
//   result side: digest_out/digest_valid out, digest_ack in; err_msg/err_timeout sticky flags
module lh_msg_feeder
  import lh_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int WDOG_MAX = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          msg_char,
  input  logic                msg_valid,
  input  logic                msg_last,
  output logic                msg_ready,
  output logic                msg_drop,
  output logic [7:0]          ptxt_char,
  output logic                ptxt_valid,
  input  logic                core_busy,
  input  logic [DIGEST_W-1:0] digest_char,
  input  logic                digest_ready,
  input  logic                err_invalid_ptxt_char,
  output logic [DIGEST_W-1:0] digest_out,
  output logic                digest_valid,
  input  logic                digest_ack,
  output logic                err_msg,
  output logic                err_timeout
);
  localparam int WW = $clog2(WDOG_MAX + 1);
  state_t state;
  logic [ENTRY_W-1:0] head;
  logic full, empty, push, pop, last_seen, end_sent;
  logic [WW-1:0] wdog;
  assign msg_ready = !full;
  assign push = msg_valid && msg_ready && !is_mark(msg_char);
  // ptxt_valid is only high in FETCH on the cycle the head entry is being strobed
  assign pop = state == FETCH && ptxt_valid;
  lh_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata({msg_last, msg_char}),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) msg_drop <= 1'b0;
    else msg_drop <= msg_valid && msg_ready && is_mark(msg_char);
  // Strobes are loaded on the edge entering their state so ptxt_valid is high exactly during it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptxt_char <= '0;
      ptxt_valid <= 1'b0;
      last_seen <= 1'b0;
      end_sent <= 1'b0;
      wdog <= '0;
      digest_out <= '0;
      digest_valid <= 1'b0;
      err_msg <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ptxt_valid <= 1'b0;
      case (state)
        IDLE:
          if (!empty && !digest_valid) begin
            state <= SEND_START;
            ptxt_valid <= 1'b1;
            ptxt_char <= START_MARK;
          end
        SEND_START: begin
          err_msg <= 1'b0;
          err_timeout <= 1'b0;
          last_seen <= 1'b0;
          end_sent <= 1'b0;
          state <= GAP;
        end
        GAP: begin
          // data bytes can never be markers, so a non-marker ptxt_char means a data strobe preceded
          if (err_invalid_ptxt_char && !is_mark(ptxt_char)) err_msg <= 1'b1;
          state <= WAIT_CORE;
        end
        WAIT_CORE:
          if (!core_busy) begin
            if (end_sent) begin
              state <= WAIT_DIGEST;
              wdog <= WW'(1);
            end else if (last_seen) begin
              state <= SEND_END;
              ptxt_valid <= 1'b1;
              ptxt_char <= END_MARK;
            end else begin
              state <= FETCH;
              if (!empty) begin
                ptxt_valid <= 1'b1;
                ptxt_char <= head[7:0];
              end
            end
          end
        FETCH:
          if (ptxt_valid) begin
            last_seen <= head[8];
            state <= GAP;
          end else if (!empty) begin
            ptxt_valid <= 1'b1;
            ptxt_char <= head[7:0];
          end
        SEND_END: begin
          end_sent <= 1'b1;
          state <= GAP;
        end
        WAIT_DIGEST:
          if (digest_ready) begin
            digest_out <= digest_char;
            digest_valid <= 1'b1;
            state <= HOLD;
          end else if (wdog == WW'(WDOG_MAX)) begin
            err_timeout <= 1'b1;
            state <= IDLE;
          end else wdog <= wdog + 1'b1;
        HOLD:
          if (digest_ack) begin
            digest_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lh_msg_feeder.sv
// tb_lh_msg_feeder: scoreboard bench with a host driver, a core/digest responder and an output monitor
module tb_lh_msg_feeder;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] msg_char = '0, ptxt_char;
  logic msg_valid = 1'b0, msg_last = 1'b0, msg_ready, msg_drop, ptxt_valid;
  logic core_busy = 1'b0, digest_ready = 1'b0, err_invalid = 1'b0, digest_ack = 1'b0;
  logic [63:0] digest_char = '0, digest_out;
  logic digest_valid, err_msg, err_timeout;
  always #5 clk = ~clk;
  lh_msg_feeder #(.FIFO_DEPTH(16), .WDOG_MAX(255)) dut (
    .clk(clk), .rst(rst), .msg_char(msg_char), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_ready(msg_ready), .msg_drop(msg_drop), .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid),
    .core_busy(core_busy), .digest_char(digest_char), .digest_ready(digest_ready),
    .err_invalid_ptxt_char(err_invalid), .digest_out(digest_out), .digest_valid(digest_valid),
    .digest_ack(digest_ack), .err_msg(err_msg), .err_timeout(err_timeout)
  );
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] exp_q[$];
  logic [63:0] dexp_q[$];
  bit errexp_q[$];
  logic [7:0] mbuf[$];
  int exp_drops = 0;
  bit busy_rand = 0, core_hold = 0, err_rand = 0, dig_mute = 0, exact_gap = 0;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  // core and digest responder: drives core-side inputs just after each rising edge
  int busy_cnt = 0, dig_wait = 0, dig_n = 0, ack_wait = -1;
  bit pend_err = 0, inj_err = 0, dig_pend = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      core_busy = 0; err_invalid = 0; digest_ready = 0; digest_ack = 0;
      busy_cnt = 0; pend_err = 0; inj_err = 0; dig_pend = 0; ack_wait = -1;
    end else begin
      err_invalid = pend_err;
      pend_err = 0;
      if (err_invalid) inj_err = 1;
      if (busy_cnt > 0) busy_cnt--;
      if (ptxt_valid) begin
        busy_cnt = busy_rand ? $urandom_range(0, 4) : 0;
        if (ptxt_char == 8'hFF) inj_err = 0;
        else if (ptxt_char == 8'h00) begin
          if (!dig_mute) begin
            dig_pend = 1;
            dig_wait = $urandom_range(0, 6);
            errexp_q.push_back(inj_err);
          end
        end else pend_err = err_rand && ($urandom_range(0, 5) == 0);
      end
      core_busy = core_hold || busy_cnt > 0;
      if (digest_ready && digest_valid) begin
        digest_ready = 0;
        dig_pend = 0;
        digest_char = {$urandom, $urandom};
      end else if (dig_pend && !digest_ready) begin
        if (dig_wait > 0) dig_wait--;
        else begin
          digest_ready = 1;
          digest_char = (dig_n == 0) ? 64'h0123456789ABCDEF : {$urandom, $urandom};
          dexp_q.push_back(digest_char);
          dig_n++;
        end
      end
      digest_ack = 0;
      if (digest_valid) begin
        if (ack_wait < 0) ack_wait = (dig_n == 1) ? 5 : $urandom_range(1, 5);
        ack_wait--;
        if (ack_wait == 0) begin
          digest_ack = 1;
          ack_wait = -1;
        end
      end else digest_ack = ($urandom_range(0, 15) == 0);
    end
  end
  // monitor: compares every DUT presentation against the scoreboard queues
  int last_cyc = -100, strobes = 0, data_strobes = 0, end_cyc = 0, drops_seen = 0;
  int hold_cnt = 0, digests_seen = 0;
  logic [7:0] last_char = '0;
  logic [63:0] held = '0;
  bit prev_dv = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_cyc = -100;
      last_char = '0;
      prev_dv = 0;
    end else begin
      if (ptxt_valid) begin
        strobes++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got %h want none", ptxt_char);
        end else check("ptxt_char", 64'(ptxt_char), 64'(exp_q.pop_front()));
        if (ptxt_char != 8'h00 && ptxt_char != 8'hFF) data_strobes++;
        if (ptxt_char == 8'h00) end_cyc = cyc;
        if (last_cyc >= 0) begin
          if (exact_gap && last_char != 8'h00) check("strobe_gap", 64'(cyc - last_cyc), 64'd3);
          else check("min_gap", 64'(cyc - last_cyc >= 3), 64'd1);
        end
        last_cyc = cyc;
        last_char = ptxt_char;
      end else check("ptxt_hold", 64'(ptxt_char), 64'(last_char));
      if (msg_drop) drops_seen++;
      if (digest_valid && !prev_dv) begin
        if (dexp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_digest: got %h want none", digest_out);
        end else check("digest_out", digest_out, dexp_q.pop_front());
        if (errexp_q.size() != 0) check("err_msg", 64'(err_msg), 64'(errexp_q.pop_front()));
        check("err_timeout_clear", 64'(err_timeout), 64'd0);
        held = digest_out;
        hold_cnt = 0;
      end
      if (digest_valid) begin
        hold_cnt++;
        check("digest_stable", digest_out, held);
      end
      if (!digest_valid && prev_dv) begin
        digests_seen++;
        if (digests_seen == 1) check("hold_cycles", 64'(hold_cnt), 64'd5);
      end
      prev_dv = digest_valid;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] c, input bit last);
    int n = 0;
    bit ok;
    msg_char = c;
    msg_last = last;
    msg_valid = 1;
    do begin
      ok = msg_ready;
      step();
      n++;
    end while (!ok && n < 2000);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h got not-accepted want accepted", c);
    end
    msg_valid = 0;
    if (busy_rand && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
  endtask
  task automatic send_buf();
    exp_q.push_back(8'hFF);
    foreach (mbuf[i]) begin
      if (mbuf[i] == 8'h00 || mbuf[i] == 8'hFF) exp_drops++;
      else exp_q.push_back(mbuf[i]);
      send_byte(mbuf[i], i == mbuf.size() - 1);
    end
    exp_q.push_back(8'h00);
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || dexp_q.size() != 0 || dig_pend || digest_valid) && n < 5000) begin
      @(posedge clk);
      #3;
      n++;
    end
    check("drain", 64'(exp_q.size() + dexp_q.size()), 64'd0);
    step();
  endtask
  initial begin
    int n, d0, s0;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_msg_ready", 64'(msg_ready), 64'd1);
    check("rst_ptxt_valid", 64'(ptxt_valid), 64'd0);
    check("rst_ptxt_char", 64'(ptxt_char), 64'd0);
    check("rst_msg_drop", 64'(msg_drop), 64'd0);
    check("rst_digest_valid", 64'(digest_valid), 64'd0);
    check("rst_digest_out", digest_out, 64'd0);
    check("rst_err_msg", 64'(err_msg), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    rst = 0;
    step();
    exact_gap = 1;
    mbuf = '{8'h61, 8'h62, 8'h63};
    send_buf();
    wait_drain();
    exact_gap = 0;
    d0 = drops_seen;
    mbuf = '{8'hFF, 8'h61};
    send_buf();
    wait_drain();
    check("drop_pulses", 64'(drops_seen - d0), 64'd1);
    core_hold = 1;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      send_byte(8'(8'h10 + i), 0);
    end
    check("full_ready", 64'(msg_ready), 64'd0);
    repeat (4) step();
    check("full_ready_held", 64'(msg_ready), 64'd0);
    core_hold = 0;
    exp_q.push_back(8'h20);
    send_byte(8'h20, 1);
    exp_q.push_back(8'h00);
    wait_drain();
    exp_q.push_back(8'hFF);
    d0 = data_strobes;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(8'h30 + i));
      send_byte(8'(8'h30 + i), 0);
    end
    n = 0;
    while (data_strobes < d0 + 2 && n < 200) begin
      step();
      n++;
    end
    check("two_strobed", 64'(data_strobes - d0), 64'd2);
    rst = 1;
    #1;
    check("mid_rst_ptxt_valid", 64'(ptxt_valid), 64'd0);
    check("mid_rst_msg_ready", 64'(msg_ready), 64'd1);
    check("mid_rst_ptxt_char", 64'(ptxt_char), 64'd0);
    check("mid_rst_digest_valid", 64'(digest_valid), 64'd0);
    exp_q.delete();
    repeat (2) step();
    rst = 0;
    s0 = strobes;
    repeat (40) step();
    check("no_strobe_after_rst", 64'(strobes - s0), 64'd0);
    dig_mute = 1;
    mbuf = '{8'h78};
    send_buf();
    n = 0;
    while (!err_timeout && n < 600) begin
      step();
      n++;
    end
    check("timeout_cycles", 64'(cyc - end_cyc), 64'd258);
    check("timeout_digest_valid", 64'(digest_valid), 64'd0);
    dig_mute = 0;
    wait_drain();
    busy_rand = 1;
    err_rand = 1;
    repeat (25) begin
      mbuf.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(1, 254));
        if (i < n - 1 && $urandom_range(0, 9) == 0) b = $urandom_range(0, 1) ? 8'h00 : 8'hFF;
        mbuf.push_back(b);
      end
      send_buf();
    end
    wait_drain();
    check("drop_total", 64'(drops_seen), 64'(exp_drops));
    check("errexp_empty", 64'(errexp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
